// File: rtl/sel3_dispatch_sched_pkg.sv
// rtl/sel3_dispatch_sched_pkg.sv - shared constants and types for the 3-lane dispatch scheduler
package sel3_sched_pkg;

  localparam int NLANE = 3;
  localparam int CW = 3;
  localparam logic [1:0] DEST_ANY = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  function automatic logic [NLANE-1:0] lane_onehot(input logic [1:0] lane);
    return 3'b001 << lane;
  endfunction

endpackage

// File: rtl/sel3_dispatch_sched_if.sv
// rtl/sel3_dispatch_sched_if.sv - upstream word handshake, selector drive/ack and credit bundle
interface sel3_dispatch_sched_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [1:0]            dest;
  logic [2:0]            lane_en;
  logic                  drive;
  logic [DATA_WIDTH+2:0] word;
  logic                  sel_free;
  logic [2:0]            free_next;
  logic [8:0]            credit;
  logic                  err;

  modport master (
    output valid, data, dest, lane_en, sel_free, free_next,
    input  ready, drive, word, credit, err
  );

  modport slave (
    input  valid, data, dest, lane_en, sel_free, free_next,
    output ready, drive, word, credit, err
  );
endinterface

// File: rtl/sel3_dispatch_sched_rr_pick3.sv
// rtl/sel3_dispatch_sched_rr_pick3.sv - combinational round-robin picker over three lanes
module rr_pick3 (
  input  logic [2:0] ok,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic       any
);

  function automatic logic [1:0] next_lane(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic [1:0] c1;
  logic [1:0] c2;

  // Search starts just after the last granted lane, so that lane comes last.
  always_comb begin
    gnt = '0;
    c1  = next_lane(ptr);
    c2  = next_lane(c1);
    if (ok[c1])       gnt[c1]  = 1'b1;
    else if (ok[c2])  gnt[c2]  = 1'b1;
    else if (ok[ptr]) gnt[ptr] = 1'b1;
    any = |ok;
  end

endmodule

// File: rtl/sel3_dispatch_sched.sv
// rtl/sel3_dispatch_sched.sv - dispatch scheduler: lane choice, drive/ack FSM, per-lane credits
module sel3_dispatch_sched
  import sel3_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 2,
  parameter int TIMEOUT    = 255
) (
  input logic                  clk,
  input logic                  rst,
  sel3_dispatch_sched_if.slave bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_DRIVE = DRIVE;
  localparam logic [1:0] S_WAIT  = WAIT_ACK;

  logic [1:0]              state;
  logic [7:0]              cnt;
  logic [1:0]              ptr;
  logic [NLANE-1:0][CW-1:0] cred;
  logic [DATA_WIDTH+2:0]   word_q;
  logic                    drive_q;
  logic                    err_q;

  logic [2:0] ok;
  logic [2:0] rr_gnt;
  logic       rr_any;
  logic [2:0] sel;
  logic [1:0] sel_idx;
  logic       ready;
  logic       acc;
  logic [2:0] debit;
  logic [2:0] full;
  logic       ovf;
  logic       timeout_hit;

  always_comb begin
    ok   = '0;
    full = '0;
    for (int l = 0; l < NLANE; l++) begin
      ok[l]   = bus.lane_en[l] && (cred[l] != '0);
      full[l] = (cred[l] == CW'(CREDITS));
    end
  end

  rr_pick3 u_pick (
    .ok  (ok),
    .ptr (ptr),
    .gnt (rr_gnt),
    .any (rr_any)
  );

  // A fixed destination never reroutes: it either gets its own lane or stalls.
  always_comb begin
    sel = '0;
    if (bus.dest == DEST_ANY) sel = rr_any ? rr_gnt : 3'b000;
    else                      sel = lane_onehot(bus.dest) & ok;
    sel_idx = sel[2] ? 2'd2 : (sel[1] ? 2'd1 : 2'd0);
  end

  assign ready       = !rst && (state == S_IDLE) && (|sel);
  assign acc         = bus.valid && ready;
  assign debit       = {3{acc}} & sel;
  assign ovf         = |(bus.free_next & ~debit & full);
  assign timeout_hit = (state == S_WAIT) && !bus.sel_free && (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ptr     <= 2'd2;
      word_q  <= '0;
      drive_q <= 1'b0;
    end else begin
      drive_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (acc) begin
            word_q  <= {sel, bus.data};
            ptr     <= sel_idx;
            drive_q <= 1'b1;
            state   <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.sel_free || timeout_hit) state <= S_IDLE;
          else                             cnt   <= cnt + 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A return and a debit in the same cycle cancel; a return into a full lane is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < NLANE; l++) cred[l] <= CW'(CREDITS);
    end else begin
      for (int l = 0; l < NLANE; l++) begin
        if (bus.free_next[l] && !debit[l]) begin
          if (!full[l]) cred[l] <= cred[l] + CW'(1);
        end else if (debit[l] && !bus.free_next[l]) begin
          cred[l] <= cred[l] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     err_q <= 1'b0;
    else if (timeout_hit || ovf) err_q <= 1'b1;
  end

  assign bus.ready  = ready;
  assign bus.drive  = drive_q;
  assign bus.word   = word_q;
  assign bus.credit = cred;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sel3_dispatch_sched.sv
// tb/tb_sel3_dispatch_sched.sv - directed and randomized bench with a cycle-level behavioural model
module tb_sel3_dispatch_sched;

  localparam int DW = 32;
  localparam int CR = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sel3_dispatch_sched_if #(.DATA_WIDTH(DW)) bus ();

  sel3_dispatch_sched #(.DATA_WIDTH(DW), .CREDITS(CR), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  int            m_cred[3];
  int            m_ptr;
  bit            m_busy;
  int            m_age;
  logic [DW+2:0] m_word;
  bit            m_err;

  logic          s_ready;
  logic          s_drive;
  logic [DW+2:0] s_word;
  logic [8:0]    s_credit;
  logic          s_err;
  logic [2:0]    drv_lanes[$];
  logic [2:0]    t1_exp[4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 3; l++) m_cred[l] = CR;
    m_ptr  = 2;
    m_busy = 0;
    m_age  = 0;
    m_word = '0;
    m_err  = 0;
    drv_lanes.delete();
  endtask

  // Lane the rules grant for this request, or -1 when the word must stall.
  function automatic int pick(input logic [1:0] dest, input logic [2:0] en);
    if (dest != 2'd3) return (en[dest] && m_cred[dest] > 0) ? int'(dest) : -1;
    for (int k = 1; k <= 3; k++) begin
      int l;
      l = (m_ptr + k) % 3;
      if (en[l] && m_cred[l] > 0) return l;
    end
    return -1;
  endfunction

  task automatic step(input bit v, input logic [DW-1:0] d, input logic [1:0] dest,
                      input logic [2:0] en, input bit free, input logic [2:0] fn);
    int lane;
    bit exp_ready;
    bit acc;
    bit debit;
    @(negedge clk);
    bus.valid = v; bus.data = d; bus.dest = dest; bus.lane_en = en;
    bus.sel_free = free; bus.free_next = fn;
    #1;
    s_ready = bus.ready; s_drive = bus.drive; s_word = bus.word;
    s_credit = bus.credit; s_err = bus.err;
    lane = pick(dest, en);
    exp_ready = !m_busy && lane >= 0;
    chk("ready", s_ready, exp_ready);
    chk("drive", s_drive, m_busy && m_age == 1);
    chk("word", s_word, m_word);
    chk("credit", s_credit, {3'(m_cred[2]), 3'(m_cred[1]), 3'(m_cred[0])});
    chk("err", s_err, m_err);
    if (s_drive) drv_lanes.push_back(s_word[DW+2:DW]);
    acc = v && exp_ready;
    if (m_busy) begin
      if (m_age == 1)            m_age = 2;
      else if (free)             m_busy = 0;
      else if (m_age - 1 == TO)  begin m_err = 1; m_busy = 0; end
      else                       m_age++;
    end
    for (int l = 0; l < 3; l++) begin
      debit = acc && lane == l;
      if (fn[l] && !debit) begin
        if (m_cred[l] == CR) m_err = 1;
        else                 m_cred[l]++;
      end else if (debit && !fn[l]) m_cred[l]--;
    end
    if (acc) begin
      m_busy = 1;
      m_age  = 1;
      m_word = {3'(1 << lane), d};
      m_ptr  = lane;
    end
  endtask

  task automatic hard_reset(input string tag);
    @(negedge clk);
    #2;
    bus.valid = 1'b0; bus.free_next = 3'b000;
    rst = 1'b1;
    #1;
    chk({tag, "_ready"}, bus.ready, 1'b0);
    chk({tag, "_drive"}, bus.drive, 1'b0);
    chk({tag, "_word"}, bus.word, '0);
    chk({tag, "_err"}, bus.err, 1'b0);
    chk({tag, "_credit"}, bus.credit, 9'o222);
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.valid = 1'b1; bus.data = '0; bus.dest = 2'd3; bus.lane_en = 3'b111;
    bus.sel_free = 1'b0; bus.free_next = 3'b000;
    model_reset();
    hard_reset("reset");

    // 1: round-robin over all lanes with immediate ack
    for (int i = 0; i < 12; i++) step(1, 32'hA000_0000 + i, 2'd3, 3'b111, 1, 3'b000);
    chk("t1_count", drv_lanes.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_lane%0d", i), drv_lanes[i], t1_exp[i]);
    chk("t1_word", s_word, {3'b001, 32'hA000_0009});
    chk("t1_credit", s_credit, 9'o110);
    step(0, 0, 2'd3, 3'b111, 0, 3'b111);
    step(0, 0, 2'd3, 3'b111, 0, 3'b001);
    step(0, 0, 2'd3, 3'b111, 0, 3'b000);
    chk("t1_restored", s_credit, 9'o222);

    // 2: fixed lane runs out of credit, then resumes on a return
    for (int i = 0; i < 7; i++) step(1, 32'hB000_0000 + i, 2'd1, 3'b111, 1, 3'b000);
    chk("t2_stall_ready", s_ready, 1'b0);
    chk("t2_c1_empty", s_credit[5:3], 3'd0);
    step(1, 32'hB000_0007, 2'd1, 3'b111, 1, 3'b010);
    step(1, 32'hB000_0007, 2'd1, 3'b111, 1, 3'b000);
    chk("t2_resume_ready", s_ready, 1'b1);
    step(0, 0, 2'd1, 3'b111, 1, 3'b000);
    step(0, 0, 2'd1, 3'b111, 1, 3'b010);
    step(0, 0, 2'd1, 3'b111, 1, 3'b010);

    // 3: masked lanes and an empty lane leave only lane 2; all lanes off stalls
    for (int i = 0; i < 6; i++) step(1, 32'hC000_0000 + i, 2'd0, 3'b111, 1, 3'b000);
    drv_lanes.delete();
    step(1, 32'hC000_0010, 2'd3, 3'b101, 1, 3'b000);
    step(0, 0, 2'd3, 3'b101, 1, 3'b000);
    chk("t3_lane", drv_lanes.size() > 0 ? drv_lanes[0] : 3'b000, 3'b100);
    for (int i = 0; i < 6; i++) step(1, 32'hC000_0020 + i, 2'd3, 3'b000, 1, 3'b000);
    chk("t3_all_off", s_ready, 1'b0);
    step(0, 0, 2'd3, 3'b111, 0, 3'b101);
    step(0, 0, 2'd3, 3'b111, 0, 3'b001);

    // 4: debit and return together hold the count; return into a full lane flags overflow
    for (int i = 0; i < 3; i++) step(i == 0, 32'hD000_0000, 2'd0, 3'b111, 1, 3'b000);
    step(1, 32'hD000_0001, 2'd0, 3'b111, 1, 3'b001);
    step(0, 0, 2'd0, 3'b111, 1, 3'b000);
    chk("t4_c0_held", s_credit[2:0], 3'd1);
    chk("t4_no_err", s_err, 1'b0);
    step(0, 0, 2'd0, 3'b111, 1, 3'b000);
    step(0, 0, 2'd0, 3'b111, 1, 3'b100);
    step(0, 0, 2'd0, 3'b111, 1, 3'b000);
    chk("t4_c2_held", s_credit[8:6], 3'd2);
    chk("t4_ovf_err", s_err, 1'b1);

    // 6: reset while waiting for the selector
    step(1, 32'hE000_0000, 2'd3, 3'b111, 0, 3'b000);
    step(0, 0, 2'd3, 3'b111, 0, 3'b000);
    step(0, 0, 2'd3, 3'b111, 0, 3'b000);
    hard_reset("t6");
    step(1, 32'hE000_0001, 2'd3, 3'b111, 1, 3'b000);
    step(0, 0, 2'd3, 3'b111, 1, 3'b000);
    chk("t6_first_lane", drv_lanes.size() > 0 ? drv_lanes[0] : 3'b000, 3'b001);
    step(0, 0, 2'd3, 3'b111, 1, 3'b000);

    // 5: selector never frees, timeout after TO waiting cycles
    step(1, 32'hF000_0000, 2'd3, 3'b111, 0, 3'b000);
    step(0, 0, 2'd3, 3'b111, 0, 3'b000);
    for (int k = 0; k < TO; k++) step(0, 0, 2'd3, 3'b111, 0, 3'b000);
    chk("t5_err_not_yet", s_err, 1'b0);
    step(1, 32'hF000_0001, 2'd3, 3'b111, 0, 3'b000);
    chk("t5_err", s_err, 1'b1);
    chk("t5_ready", s_ready, 1'b1);
    step(0, 0, 2'd3, 3'b111, 1, 3'b000);
    step(0, 0, 2'd3, 3'b111, 1, 3'b000);

    // randomized traffic against the model
    hard_reset("rnd");
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] fn;
      logic [2:0] en;
      for (int l = 0; l < 3; l++) fn[l] = (m_cred[l] < CR) && ($urandom % 4 == 0);
      en = ($urandom % 4 == 0) ? 3'($urandom % 8) : 3'b111;
      step($urandom % 4 != 0, $urandom, 2'($urandom % 4), en, $urandom % 3 != 0, fn);
      if (i % 1000 == 999) hard_reset("rnd_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
